// File: rtl/lb_init_sequencer_pkg.sv
// Shared definitions for the lattice-Boltzmann obstacle-mask init sequencer:
// FSM state encoding, Avalon register map and CTRL/STATUS bit positions.
package lb_init_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  localparam logic [1:0] ADDR_CTRL      = 2'd0;
  localparam logic [1:0] ADDR_STATUS    = 2'd1;
  localparam logic [1:0] ADDR_SHIP_POS  = 2'd2;
  localparam logic [1:0] ADDR_SHIP_SIZE = 2'd3;

  localparam int CTRL_START   = 0;
  localparam int CTRL_CLR_IRQ = 1;
  localparam int CTRL_ABORT   = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ABORTED = 2;

  // Both geometry registers share the layout {8'h0, hi[7:0], 8'h0, lo[7:0]}.
  function automatic logic [31:0] pack_pair(input logic [7:0] lo, input logic [7:0] hi);
    return {8'h00, hi, 8'h00, lo};
  endfunction

endpackage

// File: rtl/lb_init_sequencer_if.sv
// Avalon-MM slave register bus plus the grid-mask write port of the init sequencer.
interface lb_init_sequencer_if #(
  parameter int X_BITS = 8,
  parameter int Y_BITS = 8
);

  logic [1:0]               address;
  logic                     chipselect;
  logic                     write_n;
  logic [31:0]              writedata;
  logic [31:0]              readdata;

  logic [X_BITS+Y_BITS-1:0] mem_addr;
  logic                     mem_wdata;
  logic                     mem_we;
  logic                     mem_ready;

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata,
    output mem_addr,
    output mem_wdata,
    output mem_we,
    input  mem_ready
  );

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata,
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    output mem_ready
  );

endinterface

// File: rtl/lb_rect_hit.sv
// Inside-rectangle test for one grid cell against the ship footprint.
// Sums are one bit wider than the operands so a ship past the grid edge clips instead of wrapping.
module lb_rect_hit #(
  parameter int X_BITS = 8,
  parameter int Y_BITS = 8
) (
  input  logic [X_BITS-1:0] x,
  input  logic [Y_BITS-1:0] y,
  input  logic [7:0]        x0,
  input  logic [7:0]        y0,
  input  logic [7:0]        w,
  input  logic [7:0]        h,
  output logic              hit
);

  localparam int XW = ((X_BITS > 8) ? X_BITS : 8) + 1;
  localparam int YW = ((Y_BITS > 8) ? Y_BITS : 8) + 1;

  logic [XW-1:0] x_ext;
  logic [XW-1:0] x_lo;
  logic [XW-1:0] x_hi;
  logic [YW-1:0] y_ext;
  logic [YW-1:0] y_lo;
  logic [YW-1:0] y_hi;
  logic          in_x;
  logic          in_y;

  assign x_ext = XW'(x);
  assign x_lo  = XW'(x0);
  assign x_hi  = XW'(x0) + XW'(w);

  assign y_ext = YW'(y);
  assign y_lo  = YW'(y0);
  assign y_hi  = YW'(y0) + YW'(h);

  // A zero width or height makes the half-open interval empty.
  assign in_x = (x_ext >= x_lo) && (x_ext < x_hi);
  assign in_y = (y_ext >= y_lo) && (y_ext < y_hi);
  assign hit  = in_x && in_y;

endmodule

// File: rtl/lb_init_sequencer.sv
// Freezes the LBM solver, rasters an obstacle mask for a rectangular ship into the
// grid memory, then releases the solver and raises an interrupt.
module lb_init_sequencer
  import lb_init_sequencer_pkg::*;
#(
  parameter int X_BITS = 8,
  parameter int Y_BITS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  lb_init_sequencer_if.slave  bus,
  output logic                solver_hold,
  input  logic                solver_idle,
  output logic                irq
);

  seq_state_e        state;
  logic [X_BITS-1:0] x;
  logic [Y_BITS-1:0] y;

  logic [7:0] pos_x;
  logic [7:0] pos_y;
  logic [7:0] size_w;
  logic [7:0] size_h;
  logic [7:0] act_x0;
  logic [7:0] act_y0;
  logic [7:0] act_w;
  logic [7:0] act_h;

  logic done;
  logic aborted;
  logic busy;

  logic bus_wr;
  logic ctrl_wr;
  logic start_req;
  logic abort_req;
  logic clr_req;
  logic start_evt;
  logic abort_evt;
  logic finish_evt;
  logic last_cell;
  logic cell_hit;
  logic [31:0] rdata;

  // CTRL bits act only in the cycle of the write; nothing about them is stored.
  assign bus_wr    = bus.chipselect && !bus.write_n;
  assign ctrl_wr   = bus_wr && (bus.address == ADDR_CTRL);
  assign start_req = ctrl_wr && bus.writedata[CTRL_START];
  assign abort_req = ctrl_wr && bus.writedata[CTRL_ABORT];
  assign clr_req   = ctrl_wr && bus.writedata[CTRL_CLR_IRQ];

  assign start_evt  = start_req && !abort_req && (state == ST_IDLE);
  assign abort_evt  = abort_req && ((state == ST_HOLD) || (state == ST_SCAN));
  assign last_cell  = (x == {X_BITS{1'b1}}) && (y == {Y_BITS{1'b1}});
  assign finish_evt = (state == ST_SCAN) && bus.mem_ready && last_cell && !abort_evt;

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_x  <= '0;
      pos_y  <= '0;
      size_w <= '0;
      size_h <= '0;
    end else if (bus_wr) begin
      if (bus.address == ADDR_SHIP_POS) begin
        pos_x <= bus.writedata[7:0];
        pos_y <= bus.writedata[23:16];
      end
      if (bus.address == ADDR_SHIP_SIZE) begin
        size_w <= bus.writedata[7:0];
        size_h <= bus.writedata[23:16];
      end
    end
  end

  // The scan works from a private copy so software may reprogram the next ship meanwhile.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_x0 <= '0;
      act_y0 <= '0;
      act_w  <= '0;
      act_h  <= '0;
    end else if (start_evt) begin
      act_x0 <= pos_x;
      act_y0 <= pos_y;
      act_w  <= size_w;
      act_h  <= size_h;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      x     <= '0;
      y     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_evt) state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (abort_evt) begin
            state <= ST_IDLE;
          end else if (solver_idle) begin
            state <= ST_SCAN;
            x     <= '0;
            y     <= '0;
          end
        end
        ST_SCAN: begin
          if (abort_evt) begin
            state <= ST_IDLE;
          end else if (bus.mem_ready) begin
            if (last_cell) begin
              state <= ST_DONE;
            end else begin
              x <= x + 1'b1;
              if (x == {X_BITS{1'b1}}) y <= y + 1'b1;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Completion and abort are applied after the clears so a coincident clr_irq loses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done    <= 1'b0;
      aborted <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (start_evt) begin
        done    <= 1'b0;
        aborted <= 1'b0;
      end
      if (clr_req) begin
        done    <= 1'b0;
        aborted <= 1'b0;
        irq     <= 1'b0;
      end
      if (finish_evt) begin
        done <= 1'b1;
        irq  <= 1'b1;
      end
      if (abort_evt) begin
        aborted <= 1'b1;
        irq     <= 1'b1;
      end
    end
  end

  lb_rect_hit #(
    .X_BITS(X_BITS),
    .Y_BITS(Y_BITS)
  ) u_rect_hit (
    .x  (x),
    .y  (y),
    .x0 (act_x0),
    .y0 (act_y0),
    .w  (act_w),
    .h  (act_h),
    .hit(cell_hit)
  );

  assign bus.mem_we    = (state == ST_SCAN);
  assign bus.mem_addr  = {y, x};
  assign bus.mem_wdata = cell_hit && (state == ST_SCAN);
  assign solver_hold   = (state == ST_HOLD) || (state == ST_SCAN);

  always_comb begin
    rdata = '0;
    case (bus.address)
      ADDR_STATUS: begin
        rdata[STAT_BUSY]    = busy;
        rdata[STAT_DONE]    = done;
        rdata[STAT_ABORTED] = aborted;
      end
      ADDR_SHIP_POS:  rdata = pack_pair(pos_x, pos_y);
      ADDR_SHIP_SIZE: rdata = pack_pair(size_w, size_h);
      default:        rdata = '0;
    endcase
  end

  assign bus.readdata = rdata;

endmodule

// File: tb/tb_lb_init_sequencer.sv
// Self-checking bench for lb_init_sequencer on an 8x8 grid: register table plus
// scoreboarded mask scans covering clipping, stalls, hold, abort and reset.
module tb_lb_init_sequencer;
  import lb_init_sequencer_pkg::*;

  localparam int XB    = 3;
  localparam int YB    = 3;
  localparam int CELLS = 64;

  logic clk = 1'b0;
  logic reset_n;
  logic solver_hold;
  logic solver_idle;
  logic irq;

  lb_init_sequencer_if #(.X_BITS(XB), .Y_BITS(YB)) bus ();

  lb_init_sequencer #(.X_BITS(XB), .Y_BITS(YB)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .solver_hold(solver_hold),
    .solver_idle(solver_idle),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] addr;
    logic       flag;
  } cell_t;

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;

  cell_t    sb[$];
  reg_vec_t vecs[6];
  int n_cmp;
  int n_fail;
  int accepted;
  int ready_mode;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock: monitor the mask port at the falling edge, then drive after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (bus.mem_we === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL unexpected_write: got addr 0x%02h, expected no write", bus.mem_addr);
      end else begin
        checkOutput("mem_cell", {25'd0, bus.mem_addr, bus.mem_wdata}, {25'd0, sb[0].addr, sb[0].flag});
        if (bus.mem_ready) begin
          void'(sb.pop_front());
          accepted++;
        end
      end
    end
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       bus.mem_ready = 1'b1;
      1:       bus.mem_ready = 1'($urandom_range(0, 1));
      default: bus.mem_ready = 1'b0;
    endcase
  endtask

  task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic checkReg(input string name, input logic [1:0] a, input logic [31:0] exp);
    bus.address = a;
    #1;
    checkOutput(name, bus.readdata, exp);
  endtask

  task automatic startScan(input int x0, input int y0, input int w, input int h);
    applyStimulus(ADDR_SHIP_POS, {8'd0, 8'(y0), 8'd0, 8'(x0)});
    applyStimulus(ADDR_SHIP_SIZE, {8'd0, 8'(h), 8'd0, 8'(w)});
    sb.delete();
    accepted = 0;
    for (int cy = 0; cy < 8; cy++) begin
      for (int cx = 0; cx < 8; cx++) begin
        cell_t c;
        c.addr = 6'(cy * 8 + cx);
        c.flag = (cx >= x0) && (cx < x0 + w) && (cy >= y0) && (cy < y0 + h);
        sb.push_back(c);
      end
    end
    applyStimulus(ADDR_CTRL, 32'h1);
  endtask

  // Runs to the DONE cycle, then checks the whole scan and the settled status.
  task automatic finishScan(input string name, input int budget);
    int n;
    n = 0;
    while (irq !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checkOutput({name, "_irq"}, {31'd0, irq}, 32'd1);
    checkReg({name, "_status_done_state"}, ADDR_STATUS, 32'h3);
    checkOutput({name, "_hold_released"}, {31'd0, solver_hold}, 32'd0);
    checkOutput({name, "_writes"}, accepted, CELLS);
    checkOutput({name, "_sb_empty"}, sb.size(), 0);
    tick();
    checkReg({name, "_status"}, ADDR_STATUS, 32'h2);
    applyStimulus(ADDR_CTRL, 32'h2);
    checkReg({name, "_status_clr"}, ADDR_STATUS, 32'h0);
    checkOutput({name, "_irq_clr"}, {31'd0, irq}, 32'd0);
  endtask

  initial begin
    int n;
    n_cmp          = 0;
    n_fail         = 0;
    accepted       = 0;
    ready_mode     = 0;
    reset_n        = 1'b0;
    solver_idle    = 1'b1;
    bus.address    = ADDR_CTRL;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    bus.mem_ready  = 1'b1;

    #2;
    for (int a = 0; a < 4; a++) checkReg("reset_readdata", 2'(a), 32'h0);
    checkOutput("reset_outputs", {29'd0, bus.mem_we, solver_hold, irq}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();

    vecs[0] = '{wr: 1'b1, addr: ADDR_SHIP_POS,  wdata: 32'h0003_0002, exp: 32'h0003_0002};
    vecs[1] = '{wr: 1'b1, addr: ADDR_SHIP_SIZE, wdata: 32'hFFFF_FFFF, exp: 32'h00FF_00FF};
    vecs[2] = '{wr: 1'b0, addr: ADDR_SHIP_POS,  wdata: 32'h0,         exp: 32'h0003_0002};
    vecs[3] = '{wr: 1'b1, addr: ADDR_CTRL,      wdata: 32'h0,         exp: 32'h0};
    vecs[4] = '{wr: 1'b0, addr: ADDR_STATUS,    wdata: 32'h0,         exp: 32'h0};
    vecs[5] = '{wr: 1'b1, addr: ADDR_SHIP_SIZE, wdata: 32'h0002_0003, exp: 32'h0002_0003};
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].wr) applyStimulus(vecs[i].addr, vecs[i].wdata);
      checkReg("reg_vec", vecs[i].addr, vecs[i].exp);
    end

    // Basic ship fully inside the grid, no stalls.
    startScan(2, 3, 3, 2);
    checkOutput("hold_after_start", {31'd0, solver_hold}, 32'd1);
    checkReg("busy_after_start", ADDR_STATUS, 32'h1);
    finishScan("basic", 500);

    // Ship hanging off the far corner, with random mem_ready stalls.
    ready_mode = 1;
    startScan(6, 6, 5, 5);
    finishScan("clip", 2000);
    ready_mode = 0;

    // Solver slow to freeze; reprogramming and restarting while busy must not disturb the scan.
    solver_idle = 1'b0;
    startScan(1, 1, 2, 2);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("hold_wait", {30'd0, solver_hold, bus.mem_we}, 32'h2);
    end
    applyStimulus(ADDR_SHIP_POS, 32'h0);
    applyStimulus(ADDR_SHIP_SIZE, 32'h0);
    checkReg("busy_pos_visible", ADDR_SHIP_POS, 32'h0);
    applyStimulus(ADDR_CTRL, 32'h1);
    solver_idle = 1'b1;
    finishScan("hold", 500);

    // Zero width writes an all-clear mask.
    startScan(0, 0, 0, 5);
    finishScan("zero_w", 500);

    // Abort with cell 20 on the port.
    startScan(0, 0, 8, 8);
    n = 0;
    while (accepted < 20 && n < 200) begin
      tick();
      n++;
    end
    checkOutput("abort_cell", {26'd0, bus.mem_addr}, 32'd20);
    ready_mode    = 2;
    bus.mem_ready = 1'b0;
    applyStimulus(ADDR_CTRL, 32'h4);
    sb.delete();
    checkOutput("abort_outputs", {30'd0, bus.mem_we, solver_hold}, 32'd0);
    checkReg("abort_status", ADDR_STATUS, 32'h4);
    checkOutput("abort_irq", {31'd0, irq}, 32'd1);
    ready_mode = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("abort_quiet", {31'd0, bus.mem_we}, 32'd0);
    end
    applyStimulus(ADDR_CTRL, 32'h2);
    checkReg("abort_clr", ADDR_STATUS, 32'h0);
    applyStimulus(ADDR_CTRL, 32'h4);
    checkReg("idle_abort", ADDR_STATUS, 32'h0);
    checkOutput("idle_abort_irq", {31'd0, irq}, 32'd0);
    applyStimulus(ADDR_CTRL, 32'h5);
    tick();
    checkReg("start_abort_same", ADDR_STATUS, 32'h0);
    checkOutput("start_abort_hold", {31'd0, solver_hold}, 32'd0);

    // Reset mid-scan, then a fresh scan with new geometry.
    startScan(2, 3, 3, 2);
    n = 0;
    while (accepted < 10 && n < 200) begin
      tick();
      n++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("rst_outputs", {29'd0, bus.mem_we, solver_hold, irq}, 32'd0);
    checkReg("rst_status", ADDR_STATUS, 32'h0);
    checkReg("rst_pos", ADDR_SHIP_POS, 32'h0);
    sb.delete();
    for (int i = 0; i < 3; i++) tick();
    reset_n = 1'b1;
    tick();
    startScan(5, 1, 2, 4);
    finishScan("after_reset", 500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lb_init_sequencer.md
LB_INIT_SEQUENCER -- requirements
Module: lb_init_sequencer

Interface
REQ-001 SHALL have parameter X_BITS, default 8: grid column address width.
REQ-002 SHALL have parameter Y_BITS, default 8: grid row address width.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports address (input, 2), chipselect (input, 1), write_n (input, 1) and writedata (input, 32): Avalon-MM slave write; zero wait states.
REQ-006 SHALL have port readdata, output, 32: combinational read mux of the addressed register.
REQ-007 SHALL have ports mem_addr (output, X_BITS+Y_BITS, {y,x}), mem_wdata (output, 1, obstacle flag), mem_we (output, 1) and mem_ready (input, 1): grid-mask write port.
REQ-008 SHALL have ports solver_hold (output, 1: LBM solver freeze request) and solver_idle (input, 1: solver acknowledges it is frozen).
REQ-009 SHALL have port irq, output, 1: level, set on completion or abort.

Function
REQ-010 Register map SHALL be: addr0 CTRL (W: bit0 start, bit1 clr_irq, bit2 abort; reads 0); addr1 STATUS (R: bit0 busy, bit1 done, bit2 aborted); addr2 SHIP_POS (R/W: [7:0] x0, [23:16] y0); addr3 SHIP_SIZE (R/W: [7:0] w, [23:16] h).
REQ-011 CTRL bits SHALL be single-cycle pulses that are never stored.
REQ-012 SHIP_POS and SHIP_SIZE SHALL be latched into shadow registers on accepted start; writes to them while busy SHALL update the visible registers but not the active scan.
REQ-013 FSM states SHALL be IDLE, HOLD, SCAN, DONE.
REQ-014 IDLE -> HOLD on a start write; solver_hold SHALL go high the cycle after the write.
REQ-015 HOLD -> SCAN on the first cycle solver_idle=1; x and y SHALL clear to 0.
REQ-016 SCAN SHALL raster x fastest, then y, over all 2^(X_BITS+Y_BITS) cells.
REQ-017 In SCAN, mem_we SHALL be 1, with mem_addr/mem_wdata stable until mem_ready=1 is sampled; the cell then advances on the next clock.
REQ-018 mem_wdata SHALL be 1 iff x0<=x<x0+w and y0<=y<y0+h, using 9-bit (Y/X_BITS+1) sums, so a ship extending past the grid edge clips without wrap; w=0 or h=0 SHALL write all zeros.
REQ-019 After the write of the last cell ({all ones}) is accepted, the FSM SHALL enter DONE; DONE SHALL set done and irq, deassert solver_hold, and return to IDLE after one cycle.
REQ-020 A start while not IDLE SHALL be ignored.
REQ-021 An abort in HOLD or SCAN SHALL return the FSM to IDLE on the next cycle, drop mem_we and solver_hold, and set aborted and irq; an abort in IDLE SHALL have no effect.
REQ-022 Start and abort in the same write SHALL be resolved as abort.
REQ-023 clr_irq SHALL clear irq, done and aborted; a clr_irq coincident with a completion or abort event SHALL lose to the set.
REQ-024 An accepted start SHALL clear done and aborted.
REQ-025 busy SHALL equal (state != IDLE).

Reset
REQ-026 reset_n low SHALL force state IDLE, all registers and shadow registers to 0, and readdata 0 with mem_we, solver_hold and irq all 0, without waiting for clk.
REQ-027 A reset asserted mid-SCAN SHALL abandon the scan with no further mem_we pulses.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, register address constants and CTRL/STATUS bit indices.
REQ-029 The inside-rectangle comparator SHALL be a sub-module, lb_rect_hit.

Verification
REQ-030 With X_BITS=Y_BITS=3, pos (2,3), size (3,2), solver_idle=1 and mem_ready=1, start SHALL produce 64 writes with exactly cells y=3..4, x=2..4 flagged 1, then irq=1 and STATUS=0b010.
REQ-031 With pos (6,6) and size (5,5) on an 8x8 grid, only x,y in 6..7 SHALL be flagged, with no wrap to low cells.
REQ-032 Holding solver_idle=0 for 10 cycles after start SHALL give solver_hold=1 with no mem_we until solver_idle rises.
REQ-033 Random mem_ready stalls SHALL keep addr/data stable while stalled, with no skipped or duplicated cells.
REQ-034 Abort at cell 20 SHALL give mem_we=0 the next cycle, STATUS=0b100 and irq=1; a subsequent clr_irq SHALL return STATUS to 0.
REQ-035 Asserting reset_n low mid-SCAN and then starting again SHALL cause the scan to restart from cell 0 using the new parameters.
